core_arbiter: RTL
=================

# core_arbiter

Two-to-one arbiter that shares one core memory port (req/gnt/rvalid protocol) between two requesters, e.g. the Ibex instruction and data ports feeding a single `axi4l2core` bridge. Selection is round-robin, and the selection is locked while a request is pending and not yet granted. Up to `DEPTH` transactions may be outstanding; an owner FIFO routes each `rvalid`/`rdata`/`err` back to the requester that issued it, in order.

## Interface
- `DEPTH`, 2: maximum outstanding granted-but-unanswered transactions (≥1).
- `aclk`  in  1  clock.
- `areset`  in  1  reset, asynchronous, active-high.
- `m0`  core_if.slave  —  requester 0: req, we, be[3:0], addr[31:0], wdata[31:0] in; gnt, rvalid, rdata[31:0], err out.
- `m1`  core_if.slave  —  requester 1, same signals as `m0`.
- `s`  core_if.master  —  shared port: req, we, be, addr, wdata out; gnt, rvalid, rdata, err in.
- `protocol_err`  out  1  sticky flag: `s.rvalid` was seen with no transaction outstanding.

## Operation
- State registers:
  - `rr_last` (1 bit): last granted requester. Resets to 1, so m0 wins first.
  - `locked`/`lock_id`: a request was presented and not granted.
  - Owner FIFO: `DEPTH` entries × 1 bit, with rd/wr pointers and `count` of width $clog2(DEPTH+1).
  - `protocol_err`.
- Winner selection, combinational:
  - If `locked`, winner = `lock_id`, regardless of the other requester.
  - Else if only one requester has req high, that requester wins.
  - Else if both are high, winner = `!rr_last`.
- Forwarding: `s.req = winner_req && (count != DEPTH)`. `s.we/be/addr/wdata` = winner's fields.
  - When no requester is active, the m0 fields are driven.
- Grant: `mX.gnt = s.gnt && s.req && (winner == X)`. The losing requester never sees gnt.
- On grant (`s.req && s.gnt`):
  - Push winner id into the FIFO.
  - `rr_last <= winner`.
  - `locked <= 0`.
- On `s.req && !s.gnt`: `locked <= 1`, `lock_id <= winner`. This keeps the address and data stable toward the slave until it grants.
- Full FIFO (`count == DEPTH`): `s.req` is held low and `locked` is unchanged. There is no bypass: a pop in the same cycle does not enable a push.
- Response routing, on `s.rvalid`:
  - If `count > 0`: owner = FIFO head. `owner.rvalid = 1`, `owner.rdata = s.rdata`, `owner.err = s.err`. Pop the FIFO.
  - The other requester's rvalid stays 0.
  - rdata/err are broadcast to both requesters; only rvalid is qualified.
- `s.rvalid` with `count == 0`: the response is dropped, no rvalid is forwarded, and `protocol_err <= 1`. It clears only on reset.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. The pointers wrap modulo `DEPTH`.
- A requester dropping req while locked is an upstream protocol violation. The lock is released and `s.req` follows the new winner.
- Reset mid-operation clears all state immediately. In-flight responses arriving after reset raise `protocol_err`.

## Timing
- Reset values:
  - `s.req=0`, `m0.gnt=m1.gnt=0`, `m0.rvalid=m1.rvalid=0`, `protocol_err=0`.
  - `count=0`, `locked=0`, `rr_last=1`.
- Zero-cycle paths, all combinational: req→`s.req`, `s.gnt`→`mX.gnt`, `s.rvalid`/`rdata`/`err`→owner.
- `s.rvalid` in the same cycle as its own grant is not supported. A response must arrive ≥1 cycle after its grant, which matches `axi4l2core` (earliest is the cycle after).
- Lock takes effect in the cycle after an ungranted request and persists until the grant cycle.
- Round-robin pointer updates on the grant edge. Back-to-back contention alternates m0, m1, m0, …
- Registers update on posedge `aclk`. `areset` acts immediately.

## Test plan
- **Contention.** m0 and m1 both hold req, slave grants every cycle with rvalid one cycle later.
  - Grants go m0, m1, m0, m1.
  - Each rvalid reaches the matching requester in order.
  - m0 sees rdata 0xA0 and m1 sees 0xB1 as driven.
- **Lock.** Only m1 requests at addr 0x100 and the slave stalls gnt for 3 cycles. m0 raises req in cycle 1.
  - `s.addr` stays 0x100 and m1 gets gnt in cycle 3.
  - m0 is granted in the following cycle.
- **Full.** DEPTH=2, slave grants but withholds rvalid.
  - After 2 grants, `s.req` is 0 despite m0 req.
  - After one rvalid, `s.req` rises the next cycle.
- **Error and routing.** m0 write, then m1 read. The slave answers the write with err=1 and the read with rdata 0xDEADBEEF, err=0.
  - m0 sees rvalid with err=1.
  - m1 sees rvalid with rdata 0xDEADBEEF and err=0.
- **Spurious rvalid.** `s.rvalid` pulses with count 0.
  - No `mX.rvalid` is asserted.
  - `protocol_err` is set next cycle and stays set until `areset`.
- **Reset mid-transaction.** Assert `areset` while one transaction is outstanding and the arbiter is locked.
  - All outputs go 0 immediately.
  - After release, the first grant goes to m0.

Source files
------------

// File: rtl/core_arbiter_if.sv
// Core memory port bundle: req/gnt address handshake with in-order rvalid responses.
interface core_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/core_arbiter.sv
// Round-robin 2:1 arbiter onto one core memory port; an owner FIFO routes
// each in-order response back to the requester that issued it.
module core_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic   aclk,
   input  logic   areset,
   core_if.slave  m0,
   core_if.slave  m1,
   core_if.master s,
   output logic   protocol_err
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic             rr_last;
   logic             locked;
   logic             lock_id;
   logic [DEPTH-1:0] owner_q;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             lock_hold;
   logic             winner;
   logic             winner_req;
   logic             full;
   logic             push;
   logic             pop;
   logic             head;

   // A lock only holds while its owner still requests; a dropped req frees the port.
   always_comb begin
      lock_hold = locked && (lock_id ? m1.req : m0.req);
      winner    = 1'b0;
      if (lock_hold)
         winner = lock_id;
      else if (m0.req && m1.req)
         winner = ~rr_last;
      else if (m1.req)
         winner = 1'b1;
   end

   assign winner_req = winner ? m1.req : m0.req;
   assign full       = (count == FULL_CNT);

   assign s.req   = winner_req && !full && !areset;
   assign s.we    = winner ? m1.we    : m0.we;
   assign s.be    = winner ? m1.be    : m0.be;
   assign s.addr  = winner ? m1.addr  : m0.addr;
   assign s.wdata = winner ? m1.wdata : m0.wdata;

   assign m0.gnt = s.gnt && s.req && !winner;
   assign m1.gnt = s.gnt && s.req && winner;

   assign push = s.req && s.gnt;
   assign pop  = s.rvalid && (count != '0);
   assign head = owner_q[rd_ptr];

   assign m0.rvalid = pop && !head;
   assign m1.rvalid = pop && head;
   assign m0.rdata  = s.rdata;
   assign m1.rdata  = s.rdata;
   assign m0.err    = s.err;
   assign m1.err    = s.err;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rr_last      <= 1'b1;
         locked       <= 1'b0;
         lock_id      <= 1'b0;
         owner_q      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (push) begin
            owner_q[wr_ptr] <= winner;
            wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            rr_last         <= winner;
         end
         if (pop)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         // While full the request is masked, so the lock state must not be touched.
         if (!full) begin
            locked <= s.req && !s.gnt;
            if (s.req && !s.gnt)
               lock_id <= winner;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (s.rvalid && (count == '0))
            protocol_err <= 1'b1;
      end
   end
endmodule
